muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
Multicycle sequencer for the shared iterative multiply/divide unit of the MIPS datapath.
- Accepts a one-cycle start request from the main control FSM.
- Drives the unit's load, step and sign-fix strobes for a fixed number of iterations, then writes HI/LO.
- Reports completion to the main FSM, or raises the divide-by-zero exception without running the unit.

Parameters:
STEPS, 32, number of iteration cycles (operand width)
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > STEPS

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  request from main control; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV; sampled with start
divisor_zero  input  1  divisor operand is zero; sampled with start
busy  output  1  1 in every state except IDLE
done  output  1  one-cycle completion pulse
div_zero_exc  output  1  one-cycle divide-by-zero exception pulse
md_op  output  1  latched op, held stable while busy
md_load  output  1  load operands into unit, clear partial results
md_step  output  1  perform one iteration
md_fix_sign  output  1  DIV-only final sign-correction cycle
hi_write  output  1  write HI register
lo_write  output  1  write LO register
step_count  output  CNT_W  current iteration index

Behaviour:
- All state changes occur on the rising edge of clk.
- reset=0 at an edge forces IDLE, counter=0, md_op=0, and all outputs 0. This applies in any state, including mid-RUN; no HI/LO write follows an aborted operation.
- Outputs are decoded from the state register and counter only (Moore). There are no combinational input-to-output paths.
- States: IDLE, LOAD, RUN, FIX, WRITE, DONE, EXC.
- IDLE:
  - start=1 with op=1 and divisor_zero=1 -> EXC.
  - start=1 otherwise -> LOAD; md_op latches op on the same edge.
  - start=0 -> stay in IDLE.
- LOAD: md_load=1; counter cleared to 0; -> RUN.
- RUN:
  - md_step=1 and step_count=counter.
  - counter increments each cycle.
  - When counter==STEPS-1, next state is FIX if md_op=1, else WRITE.
  - Counter resets to 0 on exit.
- FIX: md_fix_sign=1 for one cycle; -> WRITE.
- WRITE: hi_write=1 and lo_write=1 for one cycle; -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- EXC: div_zero_exc=1 for one cycle; no md_load, md_step or HI/LO write; -> IDLE.
- busy=1 in LOAD, RUN, FIX, WRITE, DONE and EXC.
- step_count=0 outside RUN.
- Timing with start sampled at the end of cycle N:
  - LOAD at N+1.
  - RUN N+2 .. N+STEPS+1.
  - MULT: WRITE N+STEPS+2, done N+STEPS+3.
  - DIV: FIX N+STEPS+2, WRITE N+STEPS+3, done N+STEPS+4.
  - EXC at N+1.
- Input handling while busy:
  - start is ignored in every state other than IDLE, including DONE and EXC; there is no queuing.
  - op and divisor_zero are don't-care except when start is sampled in IDLE.
- divisor_zero with op=0 has no effect (MULT proceeds normally).
- After DONE or EXC the block returns to IDLE. A start in the following cycle is accepted, giving back-to-back operations with one idle cycle between done and the next LOAD.
- Counter arithmetic: unsigned, CNT_W bits, no wrap during RUN.
- Unreachable state encodings return to IDLE with all outputs 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1 -> state IDLE, all outputs 0, step_count=0; release -> still IDLE until start is sampled.
- MULT, STEPS=32: start=1, op=0 at cycle 0 -> md_load in cycle 1; md_step in cycles 2..33 with step_count 0..31; hi_write=lo_write=1 in cycle 34; done in cycle 35; md_fix_sign never 1; busy=1 in cycles 1..35.
- DIV: start=1, op=1, divisor_zero=0 at cycle 0 -> md_fix_sign in cycle 34; write in cycle 35; done in cycle 36; md_op=1 throughout.
- Divide by zero: start=1, op=1, divisor_zero=1 -> div_zero_exc=1 in cycle 1 only; md_load, md_step, hi_write, lo_write and done all stay 0; IDLE in cycle 2. Repeat with op=0 and divisor_zero=1 -> normal MULT completion.
- Start while busy: pulse start at cycles 5, 20 and 35 (DONE) of a MULT -> exactly one done pulse; next start at cycle 36 -> md_load in cycle 37.
- Reset mid-operation: reset=0 during RUN at step_count=10 -> next cycle IDLE with all outputs 0; no hi_write or done follows.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Handshake between the main control FSM and the multiply/divide sequencer,
// plus the strobes the sequencer drives into the iterative unit.
interface muldiv_ctrl_if #(
    parameter int CNT_W = 6
);
    // request side, driven by the main control FSM
    logic             start;
    logic             op;
    logic             divisor_zero;

    // status back to the main control FSM
    logic             busy;
    logic             done;
    logic             div_zero_exc;

    // strobes into the iterative multiply/divide datapath
    logic             md_op;
    logic             md_load;
    logic             md_step;
    logic             md_fix_sign;
    logic             hi_write;
    logic             lo_write;
    logic [CNT_W-1:0] step_count;

    modport master (
        output start,
        output op,
        output divisor_zero,
        input  busy,
        input  done,
        input  div_zero_exc,
        input  md_op,
        input  md_load,
        input  md_step,
        input  md_fix_sign,
        input  hi_write,
        input  lo_write,
        input  step_count
    );

    modport slave (
        input  start,
        input  op,
        input  divisor_zero,
        output busy,
        output done,
        output div_zero_exc,
        output md_op,
        output md_load,
        output md_step,
        output md_fix_sign,
        output hi_write,
        output lo_write,
        output step_count
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multicycle sequencer for the shared iterative multiply/divide unit.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start from main control; all strobes low
// LOAD  | load operands into the unit, clear partial results
// RUN   | one iteration per cycle, STEPS cycles, step_count = iteration
// FIX   | divide only: final sign correction of quotient/remainder
// WRITE | commit HI and LO
// DONE  | one-cycle completion pulse to main control
// EXC   | divide by zero: exception pulse, unit is never started
//
// Outputs are Moore-decoded from the state register and the iteration
// counter, so nothing on the request side reaches an output in the same
// cycle.
module muldiv_ctrl #(
    parameter int STEPS = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_ctrl_if.slave  mif
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_FIX   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5,
        S_EXC   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic             md_op_q;
    logic             accept_start;
    logic             div_by_zero;
    logic             last_step;

    // Decode of the request as seen in IDLE; op/divisor_zero are ignored
    // everywhere else.
    assign div_by_zero  = mif.op & mif.divisor_zero;
    assign accept_start = (state == S_IDLE) & mif.start;
    assign last_step    = (count == LAST_STEP);

    // State register with synchronous active-low reset; a reset mid-RUN
    // simply drops the operation, HI/LO are never written.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration counter: counts up only inside RUN and is zero everywhere
    // else, so leaving RUN (normally or otherwise) always clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if ((state == S_RUN) && !last_step) begin
            count <= count + CNT_ONE;
        end else begin
            count <= '0;
        end
    end

    // Operation latch: captured only when a real operation is launched, so
    // the unit sees a stable op for the whole sequence. A divide-by-zero
    // request never starts the unit and leaves the previous value alone.
    always_ff @(posedge clk) begin
        if (!reset) begin
            md_op_q <= 1'b0;
        end else if (accept_start && !div_by_zero) begin
            md_op_q <= mif.op;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE: begin
                if (accept_start) begin
                    state_nxt = div_by_zero ? S_EXC : S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_LOAD:  state_nxt = S_RUN;
            S_RUN: begin
                if (last_step) begin
                    state_nxt = md_op_q ? S_FIX : S_WRITE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            S_FIX:   state_nxt = S_WRITE;
            S_WRITE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_EXC:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode from state and counter.
    always_comb begin
        mif.busy         = 1'b0;
        mif.done         = 1'b0;
        mif.div_zero_exc = 1'b0;
        mif.md_op        = md_op_q;
        mif.md_load      = 1'b0;
        mif.md_step      = 1'b0;
        mif.md_fix_sign  = 1'b0;
        mif.hi_write     = 1'b0;
        mif.lo_write     = 1'b0;
        mif.step_count   = '0;
        case (state)
            S_IDLE: begin
                mif.busy = 1'b0;
            end
            S_LOAD: begin
                mif.busy    = 1'b1;
                mif.md_load = 1'b1;
            end
            S_RUN: begin
                mif.busy       = 1'b1;
                mif.md_step    = 1'b1;
                mif.step_count = count;
            end
            S_FIX: begin
                mif.busy        = 1'b1;
                mif.md_fix_sign = 1'b1;
            end
            S_WRITE: begin
                mif.busy     = 1'b1;
                mif.hi_write = 1'b1;
                mif.lo_write = 1'b1;
            end
            S_DONE: begin
                mif.busy = 1'b1;
                mif.done = 1'b1;
            end
            S_EXC: begin
                mif.busy         = 1'b1;
                mif.div_zero_exc = 1'b1;
            end
            default: begin
                // unused encoding: everything quiet, including md_op
                mif.md_op = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: per-operation timing table, directed corner
// sequences, and a randomized run against a schedule-based reference model.
module tb_muldiv_ctrl;

    localparam int STEPS = 32;
    localparam int CNT_W = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    muldiv_ctrl_if #(.CNT_W(CNT_W)) mif ();

    muldiv_ctrl #(.STEPS(STEPS), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .mif   (mif)
    );

    typedef struct packed {
        logic             busy;
        logic             done;
        logic             exc;
        logic             md_op;
        logic             load;
        logic             step;
        logic             fix;
        logic             hiw;
        logic             low;
        logic [CNT_W-1:0] sc;
    } outv_t;

    typedef struct {
        string name;
        logic  op;
        logic  dz;
        int    load_cyc;
        int    fix_cyc;
        int    write_cyc;
        int    done_cyc;
        int    exc_cyc;
        int    n_steps;
        int    busy_cycles;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    // Reference model: a queue of per-cycle expected outputs for the
    // operation in flight, built in one go when a start is accepted.
    outv_t exp_q[$];
    outv_t cur;
    logic  m_op;

    function automatic outv_t idle_v(input logic o);
        outv_t v;
        v       = '0;
        v.md_op = o;
        return v;
    endfunction

    task automatic model_edge(input logic rst_n, input logic st, input logic o, input logic dz);
        outv_t v;
        if (!rst_n) begin
            exp_q.delete();
            m_op = 1'b0;
            cur  = idle_v(1'b0);
        end else if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
        end else if (!cur.busy && st) begin
            if (o && dz) begin
                v      = idle_v(m_op);
                v.busy = 1'b1;
                v.exc  = 1'b1;
                cur    = v;
            end else begin
                m_op = o;
                v = idle_v(m_op); v.busy = 1'b1; v.load = 1'b1;
                exp_q.push_back(v);
                for (int i = 0; i < STEPS; i++) begin
                    v = idle_v(m_op); v.busy = 1'b1; v.step = 1'b1; v.sc = CNT_W'(i);
                    exp_q.push_back(v);
                end
                if (o) begin
                    v = idle_v(m_op); v.busy = 1'b1; v.fix = 1'b1;
                    exp_q.push_back(v);
                end
                v = idle_v(m_op); v.busy = 1'b1; v.hiw = 1'b1; v.low = 1'b1;
                exp_q.push_back(v);
                v = idle_v(m_op); v.busy = 1'b1; v.done = 1'b1;
                exp_q.push_back(v);
                cur = exp_q.pop_front();
            end
        end else begin
            cur = idle_v(m_op);
        end
    endtask

    function automatic outv_t dut_v();
        outv_t v;
        v.busy  = mif.busy;
        v.done  = mif.done;
        v.exc   = mif.div_zero_exc;
        v.md_op = mif.md_op;
        v.load  = mif.md_load;
        v.step  = mif.md_step;
        v.fix   = mif.md_fix_sign;
        v.hiw   = mif.hi_write;
        v.low   = mif.lo_write;
        v.sc    = mif.step_count;
        return v;
    endfunction

    task automatic check_out(input string name);
        outv_t got;
        got = dut_v();
        n_checks++;
        if (got !== cur) begin
            n_fail++;
            $display("FAIL %s cycle %0d: outputs got %h expected %h", name, cyc, got, cur);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive inputs for one cycle, clock, update the model and compare.
    task automatic tick(input logic rst_n, input logic st, input logic o, input logic dz,
                        input string name);
        reset            = rst_n;
        mif.start        = st;
        mif.op           = o;
        mif.divisor_zero = dz;
        @(posedge clk);
        model_edge(rst_n, st, o, dz);
        #1;
        cyc++;
        check_out(name);
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    vec_t tbl[4];

    initial begin
        int first_load, first_fix, first_write, first_done, first_exc;
        int n_steps, busy_cnt, sc_bad, op_bad, done_cnt, wr_cnt, sc_at_12;

        cur  = idle_v(1'b0);
        m_op = 1'b0;
        mif.start = 1'b0; mif.op = 1'b0; mif.divisor_zero = 1'b0;

        tbl[0] = '{"mult",      1'b0, 1'b0, 1, -1, 34, 35, -1, 32, 35};
        tbl[1] = '{"div",       1'b1, 1'b0, 1, 34, 35, 36, -1, 32, 36};
        tbl[2] = '{"div_zero",  1'b1, 1'b1, -1, -1, -1, -1, 1, 0, 1};
        tbl[3] = '{"mult_dz1",  1'b0, 1'b1, 1, -1, 34, 35, -1, 32, 35};

        // reset held with start asserted: must stay idle, everything zero
        tick(1'b0, 1'b1, 1'b1, 1'b0, "reset");
        tick(1'b0, 1'b1, 1'b0, 1'b0, "reset");
        check_int("reset_outputs_zero", int'(dut_v()), 0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, rbit(), rbit(), "post_reset_idle");
        check_int("post_reset_busy", int'(mif.busy), 0);

        // per-operation timing table; start is driven in cycle 0
        for (int t = 0; t < 4; t++) begin
            first_load = -1; first_fix = -1; first_write = -1; first_done = -1; first_exc = -1;
            n_steps = 0; busy_cnt = 0; sc_bad = 0; op_bad = 0;
            for (int c = 1; c <= 40; c++) begin
                if (c == 1) tick(1'b1, 1'b1, tbl[t].op, tbl[t].dz, tbl[t].name);
                else        tick(1'b1, 1'b0, rbit(), rbit(), tbl[t].name);
                if (mif.md_load && first_load < 0)                   first_load  = c;
                if (mif.md_fix_sign && first_fix < 0)                first_fix   = c;
                if (mif.hi_write && mif.lo_write && first_write < 0) first_write = c;
                if (mif.done && first_done < 0)                      first_done  = c;
                if (mif.div_zero_exc && first_exc < 0)               first_exc   = c;
                if (mif.busy) busy_cnt++;
                if (mif.md_step) begin
                    n_steps++;
                    if (int'(mif.step_count) != c - 2) sc_bad++;
                end
                if (mif.busy && !mif.div_zero_exc && mif.md_op !== tbl[t].op) op_bad++;
            end
            check_int({tbl[t].name, "_load_cycle"},  first_load,  tbl[t].load_cyc);
            check_int({tbl[t].name, "_fix_cycle"},   first_fix,   tbl[t].fix_cyc);
            check_int({tbl[t].name, "_write_cycle"}, first_write, tbl[t].write_cyc);
            check_int({tbl[t].name, "_done_cycle"},  first_done,  tbl[t].done_cyc);
            check_int({tbl[t].name, "_exc_cycle"},   first_exc,   tbl[t].exc_cyc);
            check_int({tbl[t].name, "_n_steps"},     n_steps,     tbl[t].n_steps);
            check_int({tbl[t].name, "_busy_cycles"}, busy_cnt,    tbl[t].busy_cycles);
            check_int({tbl[t].name, "_step_seq"},    sc_bad,      0);
            check_int({tbl[t].name, "_md_op_hold"},  op_bad,      0);
        end

        // start pulses at cycles 5, 20 and 35 of a MULT are ignored;
        // the start in cycle 36 is accepted with LOAD in cycle 37
        done_cnt = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, "busy_start");
        for (int c = 2; c <= 36; c++) begin
            tick(1'b1, ((c - 1) == 5) || ((c - 1) == 20) || ((c - 1) == 35), rbit(), rbit(),
                 "busy_start");
            if (mif.done) done_cnt++;
        end
        check_int("busy_start_done_pulses", done_cnt, 1);
        check_int("busy_start_idle_c36", int'(mif.busy), 0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, "back_to_back");
        check_int("back_to_back_load_c37", int'(mif.md_load), 1);
        for (int c = 0; c < 40; c++) tick(1'b1, 1'b0, rbit(), rbit(), "back_to_back_drain");

        // reset during RUN at step_count 10 (cycle 12) aborts cleanly
        sc_at_12 = -1; wr_cnt = 0; done_cnt = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b0, "mid_reset");
        for (int c = 2; c <= 12; c++) tick(1'b1, 1'b0, rbit(), rbit(), "mid_reset");
        sc_at_12 = int'(mif.step_count);
        check_int("mid_reset_step_count", sc_at_12, 10);
        tick(1'b0, 1'b0, 1'b0, 1'b0, "mid_reset");
        check_int("mid_reset_outputs_zero", int'(dut_v()), 0);
        for (int c = 0; c < 40; c++) begin
            tick(1'b1, 1'b0, rbit(), rbit(), "mid_reset_after");
            if (mif.hi_write || mif.lo_write) wr_cnt++;
            if (mif.done) done_cnt++;
        end
        check_int("mid_reset_no_write", wr_cnt, 0);
        check_int("mid_reset_no_done", done_cnt, 0);

        // randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 3) == 0),
                 rbit(),
                 ($urandom_range(0, 2) == 0),
                 "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
